madd_err_sweep_ctrl: RTL and testbench
======================================

Name: madd_err_sweep_ctrl

Overview:
- Sequencer that sweeps every input vector of a small approximate arithmetic circuit (default 6-in/4-out madd) and drives the vector to an exact and an approximate instance in parallel.
- Compares the two outputs as unsigned integers and accumulates max error, mismatch count and error sum, then flags pass/fail against an error threshold.
- Sits in the on-chip evaluation harness around the synthesised approximate netlists; the datapath instances are external to this block.

Parameters:
IN_W, 6, datapath input width; the sweep covers 2^IN_W vectors
OUT_W, 4, datapath output width
LAT, 0, datapath latency in cycles from vec_out to exact_res/approx_res; 0 means combinational
STOP_ON_FAIL, 0, 1 = stop issuing vectors at the first error > threshold

Ports:
clk  in  1  clock
rst  in  1  asynchronous active-high reset
start  in  1  one-cycle request to begin a sweep; honoured only in IDLE
et_thr  in  OUT_W  error threshold, latched on an accepted start
vec_out  out  IN_W  input vector to both datapaths
vec_valid  out  1  vec_out carries a live vector this cycle
exact_res  in  OUT_W  exact datapath output
approx_res  in  OUT_W  approximate datapath output
busy  out  1  sweep in progress (SWEEP or DRAIN)
done  out  1  one-cycle pulse when results are final
max_err  out  OUT_W  largest |exact-approx| seen
err_cnt  out  IN_W+1  number of vectors with nonzero error
err_sum  out  IN_W+OUT_W  sum of |exact-approx| over compared vectors
pass  out  1  max_err <= latched threshold; valid from done onward

Behaviour:
- Reset (async assert, sync release): state=IDLE; vec_out=0, vec_valid=0, busy=0, done=0, max_err=0, err_cnt=0, err_sum=0, pass=0; valid pipe cleared.
- States: IDLE -> SWEEP on start; SWEEP -> DRAIN after the last vector (2^IN_W-1) is issued, or after an early stop; DRAIN -> FIN when the valid pipe is empty; FIN -> IDLE unconditionally.
- Accepted start (cycle 0): latch et_thr; clear max_err, err_cnt, err_sum and pass; busy=1 from cycle 1.
- SWEEP: vector k is driven with vec_valid=1 in cycle 1+k, k = 0..2^IN_W-1, ascending. The counter is IN_W+1 bits wide so termination does not depend on wrap-around.
- Compare timing: a LAT-deep shift register carries vec_valid. Results for vector k are sampled in cycle 1+k+LAT. Accumulators update at the end of that cycle.
- Arithmetic: err = exact_res >= approx_res ? exact_res - approx_res : approx_res - exact_res (OUT_W bits, unsigned).
  - max_err = max(max_err, err).
  - err_cnt += (err != 0).
  - err_sum += err.
  - All accumulators are sized so they cannot overflow: at defaults, max err_sum = 64*15 = 960.
- DRAIN lasts exactly LAT cycles after the last issue, with vec_valid=0. When LAT=0 the block passes straight through DRAIN.
- FIN: done=1 and busy=0 for one cycle, in cycle 2^IN_W+1+LAT for a full sweep. pass is registered in this cycle.
- Results and pass hold until the next accepted start or reset.
- STOP_ON_FAIL=1: when a compare sees err > threshold, no further vectors are issued from the next cycle. Results already in flight (up to LAT) are still compared and accumulated. The block then goes through DRAIN/FIN with pass=0.
- start while busy or in FIN is ignored, with no effect on the latched threshold or the accumulators.
- Reset asserted mid-sweep aborts immediately to reset values. No done pulse is produced.
- Simultaneous start and the FIN cycle: start is ignored; a new start is needed in IDLE.
- et_thr changes during a sweep have no effect.

Test Plan:
- LAT=0, approx_res tied to exact_res, et_thr=6, start at cycle 0 -> vec_out 0..63 in cycles 1..64; done pulse in cycle 65; max_err=0, err_cnt=0, err_sum=0, pass=1.
- LAT=0, approx = exact ^ 1 for all vectors, et_thr=6 -> max_err=1, err_cnt=64, err_sum=64, pass=1.
- LAT=2, single fault: vector 0x2A gives exact=3, approx=10, all others equal, et_thr=6 -> compare of 0x2A in cycle 45; done in cycle 67; max_err=7, err_cnt=1, err_sum=7, pass=0.
- STOP_ON_FAIL=1, LAT=2, same fault -> last vec_valid in cycle 45 (vector 0x2C); two in-flight results accumulated; done in cycle 48; err_cnt=1, pass=0.
- start pulsed at cycle 10 of a sweep with et_thr=0 -> ignored; final pass is evaluated against the original threshold.
- rst asserted in cycle 30 -> all outputs 0 in the same cycle; no done pulse; a fresh start afterwards gives the nominal results of scenario 1.

Source files
------------

// File: rtl/madd_err_sweep_ctrl.sv
// Exhaustive input sweep over an exact/approximate datapath pair. Accumulates max error,
// mismatch count and error sum, then grades the result against a latched threshold.
module madd_err_sweep_ctrl #(
  parameter int unsigned IN_W         = 6,
  parameter int unsigned OUT_W        = 4,
  parameter int unsigned LAT          = 0,
  parameter bit          STOP_ON_FAIL = 1'b0
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  start,
  input  logic [OUT_W-1:0]      et_thr,
  output logic [IN_W-1:0]       vec_out,
  output logic                  vec_valid,
  input  logic [OUT_W-1:0]      exact_res,
  input  logic [OUT_W-1:0]      approx_res,
  output logic                  busy,
  output logic                  done,
  output logic [OUT_W-1:0]      max_err,
  output logic [IN_W:0]         err_cnt,
  output logic [IN_W+OUT_W-1:0] err_sum,
  output logic                  pass
);

  localparam logic [1:0] StIdle  = 2'd0;
  localparam logic [1:0] StSweep = 2'd1;
  localparam logic [1:0] StDrain = 2'd2;
  localparam logic [1:0] StFin   = 2'd3;

  // Extra counter bit keeps the last-vector test independent of wrap-around.
  localparam logic [IN_W:0] LastVec = {1'b0, {IN_W{1'b1}}};

  logic [1:0]            state_q, state_d;
  logic [IN_W:0]         cnt_q;
  logic [OUT_W-1:0]      thr_q;
  logic [OUT_W-1:0]      max_err_q;
  logic [IN_W:0]         err_cnt_q;
  logic [IN_W+OUT_W-1:0] err_sum_q;
  logic                  pass_q;

  logic                  start_ok;
  logic                  cmp_valid;
  logic                  drain_pending;
  logic                  fail_now;
  logic                  last_issue;
  logic [OUT_W-1:0]      err;

  // Valid pipeline that tracks which cycles carry a result worth comparing.
  if (LAT == 0) begin : g_no_pipe
    assign cmp_valid     = vec_valid;
    assign drain_pending = 1'b0;
  end else begin : g_pipe
    logic [LAT-1:0] pipe_q;

    always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
        pipe_q <= '0;
      end else begin
        pipe_q[0] <= vec_valid;
        for (int i = 1; i < LAT; i++) begin
          pipe_q[i] <= pipe_q[i-1];
        end
      end
    end

    assign cmp_valid = pipe_q[LAT-1];
    // Anything below the top stage still has a compare ahead of it.
    assign drain_pending = |(pipe_q << 1);
  end

  always_comb begin
    vec_valid  = (state_q == StSweep);
    vec_out    = vec_valid ? cnt_q[IN_W-1:0] : '0;
    busy       = (state_q == StSweep) || (state_q == StDrain);
    done       = (state_q == StFin);
    start_ok   = start && (state_q == StIdle);
    err        = (exact_res >= approx_res) ? (exact_res - approx_res)
                                           : (approx_res - exact_res);
    fail_now   = cmp_valid && (err > thr_q);
    last_issue = (cnt_q == LastVec) || (STOP_ON_FAIL && fail_now);
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      StIdle: begin
        if (start) state_d = StSweep;
      end
      StSweep: begin
        if (last_issue) state_d = (LAT == 0) ? StFin : StDrain;
      end
      StDrain: begin
        if (!drain_pending) state_d = StFin;
      end
      StFin: begin
        state_d = StIdle;
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q   <= StIdle;
      cnt_q     <= '0;
      thr_q     <= '0;
      max_err_q <= '0;
      err_cnt_q <= '0;
      err_sum_q <= '0;
      pass_q    <= 1'b0;
    end else begin
      state_q <= state_d;
      if (start_ok) begin
        thr_q     <= et_thr;
        cnt_q     <= '0;
        max_err_q <= '0;
        err_cnt_q <= '0;
        err_sum_q <= '0;
        pass_q    <= 1'b0;
      end else begin
        if (vec_valid) begin
          cnt_q <= cnt_q + {{IN_W{1'b0}}, 1'b1};
        end
        if (cmp_valid) begin
          if (err > max_err_q) max_err_q <= err;
          if (err != '0) err_cnt_q <= err_cnt_q + {{IN_W{1'b0}}, 1'b1};
          err_sum_q <= err_sum_q + {{IN_W{1'b0}}, err};
        end
        if (state_q == StFin) begin
          pass_q <= (max_err_q <= thr_q);
        end
      end
    end
  end

  assign max_err = max_err_q;
  assign err_cnt = err_cnt_q;
  assign err_sum = err_sum_q;
  assign pass    = pass_q;

endmodule

// File: tb/tb_madd_err_sweep_ctrl.sv
// Runs three sweep controllers (LAT=0, LAT=2, LAT=2 with stop-on-fail) side by side against
// table-driven datapaths and grades them with a whole-sweep reference model.
module tb_madd_err_sweep_ctrl;

  localparam int N = 3;

  logic       clk = 1'b0;
  logic       rst;
  logic       start;
  logic [3:0] et_thr;

  logic [5:0] vec_o  [N];
  logic       vv     [N];
  logic       busy_o [N];
  logic       done_o [N];
  logic       pass_o [N];
  logic [3:0] ex     [N];
  logic [3:0] ap     [N];
  logic [3:0] maxe   [N];
  logic [6:0] cnt_o  [N];
  logic [9:0] sum_o  [N];
  logic [5:0] d1     [N];
  logic [5:0] d2     [N];

  logic [3:0] exact_tab  [64];
  logic [3:0] approx_tab [64];

  int nchk  = 0;
  int nfail = 0;

  always #5 clk = ~clk;

  madd_err_sweep_ctrl #(.IN_W(6), .OUT_W(4), .LAT(0), .STOP_ON_FAIL(1'b0)) u_lat0 (
    .clk(clk), .rst(rst), .start(start), .et_thr(et_thr), .vec_out(vec_o[0]),
    .vec_valid(vv[0]), .exact_res(ex[0]), .approx_res(ap[0]), .busy(busy_o[0]),
    .done(done_o[0]), .max_err(maxe[0]), .err_cnt(cnt_o[0]), .err_sum(sum_o[0]),
    .pass(pass_o[0])
  );

  madd_err_sweep_ctrl #(.IN_W(6), .OUT_W(4), .LAT(2), .STOP_ON_FAIL(1'b0)) u_lat2 (
    .clk(clk), .rst(rst), .start(start), .et_thr(et_thr), .vec_out(vec_o[1]),
    .vec_valid(vv[1]), .exact_res(ex[1]), .approx_res(ap[1]), .busy(busy_o[1]),
    .done(done_o[1]), .max_err(maxe[1]), .err_cnt(cnt_o[1]), .err_sum(sum_o[1]),
    .pass(pass_o[1])
  );

  madd_err_sweep_ctrl #(.IN_W(6), .OUT_W(4), .LAT(2), .STOP_ON_FAIL(1'b1)) u_stop (
    .clk(clk), .rst(rst), .start(start), .et_thr(et_thr), .vec_out(vec_o[2]),
    .vec_valid(vv[2]), .exact_res(ex[2]), .approx_res(ap[2]), .busy(busy_o[2]),
    .done(done_o[2]), .max_err(maxe[2]), .err_cnt(cnt_o[2]), .err_sum(sum_o[2]),
    .pass(pass_o[2])
  );

  // Datapath stand-ins: instance 0 is combinational, the others see the vector two cycles late.
  always @(posedge clk) begin
    for (int i = 0; i < N; i++) begin
      d1[i] <= vec_o[i];
      d2[i] <= d1[i];
    end
  end

  always_comb begin
    ex[0] = exact_tab[vec_o[0]];
    ap[0] = approx_tab[vec_o[0]];
    for (int i = 1; i < N; i++) begin
      ex[i] = exact_tab[d2[i]];
      ap[i] = approx_tab[d2[i]];
    end
  end

  // Cycle-stamped monitor; cycle 0 is the cycle in which start is driven.
  int tick = 0;
  int base = 0;
  int nvalid   [N];
  int ndone    [N];
  int done_cyc [N];
  int seq_err  [N];

  always @(posedge clk) tick <= tick + 1;

  always @(negedge clk) begin
    int c;
    c = tick - base;
    for (int i = 0; i < N; i++) begin
      if (c == 0) begin
        nvalid[i] = 0; ndone[i] = 0; done_cyc[i] = -1; seq_err[i] = 0;
      end else begin
        if (vv[i] === 1'b1) begin
          if (vec_o[i] !== 6'(nvalid[i]) || c != 1 + nvalid[i]) seq_err[i]++;
          nvalid[i]++;
        end
        if (done_o[i] === 1'b1) begin
          ndone[i]++;
          done_cyc[i] = c;
        end
      end
    end
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    nchk++;
    assert (got === exp) else begin
      nfail++;
      $error("FAIL %s: observed %0d expected %0d", tag, got, exp);
    end
  endtask

  task automatic tick1();
    @(posedge clk);
    #1;
  endtask

  // Whole-sweep reference: which vectors get compared, what they add up to, and when done fires.
  task automatic model(input int lat, input bit stop, input int thr, output int emax,
                       output int ecnt, output int esum, output int epass, output int edone,
                       output int nvec);
    int last;
    int e;
    last = 63; emax = 0; ecnt = 0; esum = 0;
    for (int k = 0; k < 64; k++) begin
      if (k > last) break;
      e = int'(exact_tab[k]) - int'(approx_tab[k]);
      if (e < 0) e = -e;
      if (e > emax) emax = e;
      if (e != 0) ecnt++;
      esum += e;
      if (stop && e > thr && last == 63) last = (k + lat < 63) ? k + lat : 63;
    end
    nvec  = last + 1;
    edone = last + lat + 2;
    epass = (emax <= thr) ? 1 : 0;
  endtask

  task automatic check_results(input string name, input int thr);
    int emax, ecnt, esum, epass, edone, nvec;
    for (int i = 0; i < N; i++) begin
      model((i == 0) ? 0 : 2, (i == 2), thr, emax, ecnt, esum, epass, edone, nvec);
      check($sformatf("%s u%0d done_count", name, i), ndone[i], 1);
      check($sformatf("%s u%0d done_cycle", name, i), done_cyc[i], edone);
      check($sformatf("%s u%0d vec_count", name, i), nvalid[i], nvec);
      check($sformatf("%s u%0d vec_order", name, i), seq_err[i], 0);
      check($sformatf("%s u%0d max_err", name, i), 32'(maxe[i]), emax);
      check($sformatf("%s u%0d err_cnt", name, i), 32'(cnt_o[i]), ecnt);
      check($sformatf("%s u%0d err_sum", name, i), 32'(sum_o[i]), esum);
      check($sformatf("%s u%0d pass", name, i), 32'(pass_o[i]), epass);
      check($sformatf("%s u%0d busy_idle", name, i), 32'(busy_o[i]), 0);
    end
  endtask

  task automatic check_zero(input string name);
    for (int i = 0; i < N; i++) begin
      check($sformatf("%s u%0d vec_valid", name, i), 32'(vv[i]), 0);
      check($sformatf("%s u%0d vec_out", name, i), 32'(vec_o[i]), 0);
      check($sformatf("%s u%0d busy", name, i), 32'(busy_o[i]), 0);
      check($sformatf("%s u%0d done", name, i), 32'(done_o[i]), 0);
      check($sformatf("%s u%0d results", name, i),
            {20'd0, maxe[i], cnt_o[i], sum_o[i], pass_o[i]}, 0);
    end
  endtask

  // Called right after a tick1(); that cycle becomes cycle 0.
  task automatic start_sweep(input logic [3:0] thr);
    start  = 1'b1;
    et_thr = thr;
    base   = tick;
    tick1();
    start  = 1'b0;
    et_thr = 4'($urandom_range(0, 15));
  endtask

  task automatic run(input string name, input logic [3:0] thr);
    start_sweep(thr);
    repeat (79) tick1();
    check_results(name, int'(thr));
  endtask

  task automatic fill_equal();
    for (int k = 0; k < 64; k++) begin
      exact_tab[k]  = 4'($urandom_range(0, 15));
      approx_tab[k] = exact_tab[k];
    end
  endtask

  task automatic fill_fault();
    fill_equal();
    exact_tab[42]  = 4'd3;
    approx_tab[42] = 4'd10;
  endtask

  initial begin
    rst = 1'b1; start = 1'b0; et_thr = '0;
    for (int k = 0; k < 64; k++) begin
      exact_tab[k] = '0; approx_tab[k] = '0;
    end
    repeat (3) tick1();
    check_zero("reset");
    rst = 1'b0;
    tick1();

    fill_equal();
    run("equal", 4'd6);

    for (int k = 0; k < 64; k++) approx_tab[k] = exact_tab[k] ^ 4'd1;
    run("xor1", 4'd6);

    fill_fault();
    run("fault", 4'd6);

    for (int r = 0; r < 3; r++) begin
      for (int k = 0; k < 64; k++) begin
        exact_tab[k]  = 4'($urandom_range(0, 15));
        approx_tab[k] = ($urandom_range(0, 3) == 0) ? 4'($urandom_range(0, 15)) : exact_tab[k];
      end
      run($sformatf("rand%0d", r), 4'($urandom_range(0, 15)));
    end

    // start mid-sweep (cycle 10, et_thr=0) and in u_lat0's FIN cycle (65) must be ignored.
    fill_fault();
    start_sweep(4'd8);
    repeat (9) tick1();
    start = 1'b1; et_thr = 4'd0;
    tick1();
    start = 1'b0;
    repeat (54) tick1();
    start = 1'b1;
    tick1();
    start = 1'b0;
    repeat (14) tick1();
    check_results("ignored_start", 8);

    // Reset in cycle 30 aborts every sweep with no done pulse.
    fill_equal();
    start_sweep(4'd6);
    repeat (29) tick1();
    rst = 1'b1;
    #1;
    check_zero("mid_reset");
    repeat (2) tick1();
    rst = 1'b0;
    repeat (40) tick1();
    for (int i = 0; i < N; i++) check($sformatf("mid_reset u%0d no_done", i), ndone[i], 0);
    run("after_reset", 4'd6);

    $display("End of test - %0d assertions evaluated, %0d failures", nchk, nfail);
    $finish;
  end

endmodule
